// File: rtl/game_countdown_timer.sv
// BCD M:SS game-time countdown with bonus-time addition, expiry/low-time flags
// and frame-latched display digits for the VGA digit renderer.
module game_countdown_timer #(
  parameter int START_MIN     = 2,
  parameter int START_SEC     = 0,
  parameter int BONUS_SEC     = 10,
  parameter int LOW_THRESHOLD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       load,
  input  logic       decrease,
  input  logic       addTime,
  output logic [3:0] dispMin,
  output logic [3:0] dispTens,
  output logic [3:0] dispOnes,
  output logic       timeUp,
  output logic       timeOver,
  output logic       lowTime
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_ADD     = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] START_MIN_BCD  = 4'(START_MIN);
  localparam logic [3:0] START_TENS_BCD = 4'(START_SEC / 10);
  localparam logic [3:0] START_ONES_BCD = 4'(START_SEC % 10);
  localparam logic       START_IS_ZERO  = (START_MIN == 0) && (START_SEC == 0);
  localparam logic [6:0] BONUS_7        = 7'(BONUS_SEC);
  localparam logic [6:0] LOW_7          = 7'(LOW_THRESHOLD);

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [6:0] pending_q, pending_d;
  logic       owed_q, owed_d;
  logic       timeup_q, timeup_d;
  logic [3:0] disp_min_q, disp_min_d, disp_tens_q, disp_tens_d, disp_ones_q, disp_ones_d;

  logic [3:0] dec_min, dec_tens, dec_ones;
  logic [3:0] inc_min, inc_tens, inc_ones;
  logic       at_zero, at_max, dec_hits_zero;
  logic [7:0] pend_sum;
  logic [6:0] pend_sat;
  logic [6:0] secs;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      min_q       <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      pending_q   <= 7'd0;
      owed_q      <= 1'b0;
      timeup_q    <= 1'b0;
      disp_min_q  <= 4'd0;
      disp_tens_q <= 4'd0;
      disp_ones_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      pending_q   <= pending_d;
      owed_q      <= owed_d;
      timeup_q    <= timeup_d;
      disp_min_q  <= disp_min_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
    end
  end

  // BCD one-second step in each direction, plus the saturating bonus accumulator
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
    inc_min  = min_q;
    inc_tens = tens_q;
    inc_ones = ones_q + 4'd1;
    if (ones_q == 4'd9) begin
      inc_ones = 4'd0;
      inc_tens = tens_q + 4'd1;
      if (tens_q == 4'd5) begin
        inc_tens = 4'd0;
        inc_min  = min_q + 4'd1;
      end
    end
    at_zero       = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    at_max        = (min_q == 4'd9) && (tens_q == 4'd5) && (ones_q == 4'd9);
    dec_hits_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
    pend_sum      = {1'b0, pending_q} + (addTime ? {1'b0, BONUS_7} : 8'd0);
    pend_sat      = (pend_sum > 8'd127) ? 7'd127 : pend_sum[6:0];
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    pending_d = pending_q;
    owed_d    = owed_q;
    timeup_d  = 1'b0;
    if (load) begin
      min_d     = START_MIN_BCD;
      tens_d    = START_TENS_BCD;
      ones_d    = START_ONES_BCD;
      pending_d = 7'd0;
      owed_d    = 1'b0;
      state_d   = START_IS_ZERO ? S_EXPIRED : S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (addTime) begin
            // A decrement arriving with the bonus is deferred until the bonus is applied
            pending_d = pend_sat;
            owed_d    = owed_q | decrease;
            state_d   = S_ADD;
          end else if ((decrease || owed_q) && !at_zero) begin
            min_d  = dec_min;
            tens_d = dec_tens;
            ones_d = dec_ones;
            owed_d = 1'b0;
            if (dec_hits_zero) begin
              state_d  = S_EXPIRED;
              timeup_d = 1'b1;
            end
          end
        end
        S_ADD: begin
          owed_d = owed_q | decrease;
          if (at_max) begin
            pending_d = 7'd0;
            state_d   = S_RUN;
          end else begin
            min_d  = inc_min;
            tens_d = inc_tens;
            ones_d = inc_ones;
            if (pend_sat <= 7'd1) begin
              pending_d = 7'd0;
              state_d   = S_RUN;
            end else begin
              pending_d = pend_sat - 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    disp_min_d  = startOfFrame ? min_q  : disp_min_q;
    disp_tens_d = startOfFrame ? tens_q : disp_tens_q;
    disp_ones_d = startOfFrame ? ones_q : disp_ones_q;
    secs        = 7'(tens_q) * 7'd10 + 7'(ones_q);
    lowTime     = ((state_q == S_RUN) || (state_q == S_ADD)) && (min_q == 4'd0) && (secs <= LOW_7);
    timeOver    = (state_q == S_EXPIRED);
    timeUp      = timeup_q;
    dispMin     = disp_min_q;
    dispTens    = disp_tens_q;
    dispOnes    = disp_ones_q;
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer: three instances (start 2:00, 9:55, 0:00)
// share one stimulus stream; each scenario task checks its own expectations inline.
`timescale 1ns/1ps
module tb_game_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic load = 1'b0;
  logic decrease = 1'b0;
  logic addTime = 1'b0;

  logic [3:0] m_min, m_tens, m_ones, h_min, h_tens, h_ones, z_min, z_tens, z_ones;
  logic       m_up, m_over, m_low, h_up, h_over, h_low, z_up, z_over, z_low;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_countdown_timer dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .load(load),
    .decrease(decrease), .addTime(addTime), .dispMin(m_min), .dispTens(m_tens),
    .dispOnes(m_ones), .timeUp(m_up), .timeOver(m_over), .lowTime(m_low)
  );

  game_countdown_timer #(.START_MIN(9), .START_SEC(55)) dut_hi (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .load(load),
    .decrease(decrease), .addTime(addTime), .dispMin(h_min), .dispTens(h_tens),
    .dispOnes(h_ones), .timeUp(h_up), .timeOver(h_over), .lowTime(h_low)
  );

  game_countdown_timer #(.START_MIN(0), .START_SEC(0)) dut_zero (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .load(load),
    .decrease(decrease), .addTime(addTime), .dispMin(z_min), .dispTens(z_tens),
    .dispOnes(z_ones), .timeUp(z_up), .timeOver(z_over), .lowTime(z_low)
  );

  logic [11:0] live_m, live_h;
  assign live_m = {dut.min_q, dut.tens_q, dut.ones_q};
  assign live_h = {dut_hi.min_q, dut_hi.tens_q, dut_hi.ones_q};

  // One clock with the given input pulses; outputs are settled when it returns.
  task automatic cyc(input logic l, input logic d, input logic a, input logic s);
    load = l; decrease = d; addTime = a; startOfFrame = s;
    @(posedge clk);
    #1;
    load = 1'b0; decrease = 1'b0; addTime = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (live_m !== 12'h000) begin errors++; $display("FAIL reset_live got=%h exp=000", live_m); end
    checks++; if ({m_min, m_tens, m_ones} !== 12'h000) begin errors++; $display("FAIL reset_disp got=%h exp=000", {m_min, m_tens, m_ones}); end
    checks++; if ({m_up, m_over, m_low} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {m_up, m_over, m_low}); end
    reset = 1'b0;
    cyc(0, 1, 1, 0);
    checks++; if (live_m !== 12'h000) begin errors++; $display("FAIL idle_ignore got=%h exp=000", live_m); end
    checks++; if ({m_up, m_over, m_low} !== 3'b000) begin errors++; $display("FAIL idle_flags got=%b exp=000", {m_up, m_over, m_low}); end
    $display("test_reset done");
  endtask

  task automatic test_load_decrease();
    cyc(1, 0, 0, 0);
    checks++; if (live_m !== 12'h200) begin errors++; $display("FAIL load_live got=%h exp=200", live_m); end
    cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h159) begin errors++; $display("FAIL dec_live got=%h exp=159", live_m); end
    checks++; if (m_up !== 1'b0) begin errors++; $display("FAIL dec_timeup got=%b exp=0", m_up); end
    checks++; if ({m_min, m_tens, m_ones} !== 12'h000) begin errors++; $display("FAIL disp_hold got=%h exp=000", {m_min, m_tens, m_ones}); end
    cyc(0, 0, 0, 1);
    checks++; if ({m_min, m_tens, m_ones} !== 12'h159) begin errors++; $display("FAIL disp_latch got=%h exp=159", {m_min, m_tens, m_ones}); end
    $display("test_load_decrease done");
  endtask

  task automatic test_expire();
    for (int i = 0; i < 108; i++) cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h011 || m_low !== 1'b0) begin errors++; $display("FAIL at_011 got=%h low=%b exp=011 low=0", live_m, m_low); end
    cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h010 || m_low !== 1'b1) begin errors++; $display("FAIL at_010 got=%h low=%b exp=010 low=1", live_m, m_low); end
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h001 || m_up !== 1'b0) begin errors++; $display("FAIL at_001 got=%h up=%b exp=001 up=0", live_m, m_up); end
    cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h000) begin errors++; $display("FAIL expire_live got=%h exp=000", live_m); end
    checks++; if ({m_up, m_over, m_low} !== 3'b110) begin errors++; $display("FAIL expire_flags got=%b exp=110", {m_up, m_over, m_low}); end
    cyc(0, 0, 0, 0);
    checks++; if ({m_up, m_over} !== 2'b01) begin errors++; $display("FAIL timeup_single got=%b exp=01", {m_up, m_over}); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    checks++; if (live_m !== 12'h000 || m_over !== 1'b1 || m_up !== 1'b0) begin errors++; $display("FAIL expired_ignore got=%h over=%b up=%b exp=000 1 0", live_m, m_over, m_up); end
    $display("test_expire done");
  endtask

  task automatic test_bonus();
    logic [11:0] exp_seq [10];
    exp_seq = '{12'h056, 12'h057, 12'h058, 12'h059, 12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 65; i++) cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h055) begin errors++; $display("FAIL bonus_start got=%h exp=055", live_m); end
    cyc(0, 0, 1, 0);
    checks++; if (live_m !== 12'h055) begin errors++; $display("FAIL bonus_enter got=%h exp=055", live_m); end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      checks++; if (live_m !== exp_seq[i]) begin errors++; $display("FAIL bonus_step%0d got=%h exp=%h", i, live_m, exp_seq[i]); end
    end
    cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h104) begin errors++; $display("FAIL bonus_back_run got=%h exp=104", live_m); end
    $display("test_bonus done");
  endtask

  task automatic test_owed();
    logic saw_up;
    saw_up = 1'b0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 119; i++) cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h001) begin errors++; $display("FAIL owed_start got=%h exp=001", live_m); end
    cyc(0, 1, 1, 0);
    saw_up = saw_up | m_up;
    checks++; if (live_m !== 12'h001 || m_over !== 1'b0) begin errors++; $display("FAIL owed_enter got=%h over=%b exp=001 0", live_m, m_over); end
    for (int i = 0; i < 10; i++) begin
      cyc(0, (i == 3) || (i == 5), 0, 0);
      saw_up = saw_up | m_up;
    end
    checks++; if (live_m !== 12'h011) begin errors++; $display("FAIL owed_added got=%h exp=011", live_m); end
    cyc(0, 0, 0, 0);
    saw_up = saw_up | m_up;
    checks++; if (live_m !== 12'h010) begin errors++; $display("FAIL owed_applied got=%h exp=010", live_m); end
    cyc(0, 0, 0, 0);
    checks++; if (live_m !== 12'h010 || saw_up !== 1'b0 || m_over !== 1'b0) begin errors++; $display("FAIL owed_final got=%h up_seen=%b over=%b exp=010 0 0", live_m, saw_up, m_over); end
    $display("test_owed done");
  endtask

  task automatic test_saturate();
    cyc(1, 0, 0, 0);
    checks++; if (live_h !== 12'h955) begin errors++; $display("FAIL sat_load got=%h exp=955", live_h); end
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    checks++; if (live_h !== 12'h959) begin errors++; $display("FAIL sat_reach got=%h exp=959", live_h); end
    cyc(0, 0, 0, 0);
    checks++; if (live_h !== 12'h959) begin errors++; $display("FAIL sat_hold got=%h exp=959", live_h); end
    cyc(0, 1, 0, 0);
    checks++; if (live_h !== 12'h958) begin errors++; $display("FAIL sat_run got=%h exp=958", live_h); end
    cyc(0, 0, 0, 0);
    checks++; if (live_h !== 12'h958) begin errors++; $display("FAIL sat_pending_clear got=%h exp=958", live_h); end
    $display("test_saturate done");
  endtask

  task automatic test_load_zero();
    cyc(1, 0, 0, 0);
    checks++; if ({z_up, z_over, z_low} !== 3'b010) begin errors++; $display("FAIL zero_load got=%b exp=010", {z_up, z_over, z_low}); end
    cyc(0, 0, 0, 0);
    checks++; if (z_up !== 1'b0) begin errors++; $display("FAIL zero_no_timeup got=%b exp=0", z_up); end
    $display("test_load_zero done");
  endtask

  task automatic test_reset_mid_add();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    checks++; if ({m_min, m_tens, m_ones} !== 12'h201) begin errors++; $display("FAIL midadd_disp got=%h exp=201", {m_min, m_tens, m_ones}); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_min, m_tens, m_ones} !== 12'h000 || live_m !== 12'h000) begin errors++; $display("FAIL async_reset got disp=%h live=%h exp=000", {m_min, m_tens, m_ones}, live_m); end
    checks++; if ({m_up, m_over, m_low} !== 3'b000) begin errors++; $display("FAIL async_reset_flags got=%b exp=000", {m_up, m_over, m_low}); end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) cyc(0, (i == 0), 0, 0);
    checks++; if (live_m !== 12'h000 || m_over !== 1'b0) begin errors++; $display("FAIL post_reset_ignore got=%h over=%b exp=000 0", live_m, m_over); end
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    checks++; if (live_m !== 12'h159) begin errors++; $display("FAIL post_reset_clean got=%h exp=159", live_m); end
    $display("test_reset_mid_add done");
  endtask

  initial begin
    test_reset();
    test_load_decrease();
    test_expire();
    test_bonus();
    test_owed();
    test_saturate();
    test_load_zero();
    test_reset_mid_add();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
